// File: rtl/pulse_period_meter_pkg.sv
// Shared types for the pulse period meter: FSM state encoding.
package pulse_meter_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEASURE,
    S_OVERFLOW
  } meter_state_t;

endpackage

// File: rtl/pulse_period_meter_if.sv
// Strobe/measurement bundle between a strobe source/consumer (master) and the meter (slave).
interface pulse_period_meter_if #(
  parameter int N = 8
);
  logic         ena;
  logic         pulse_in;
  logic [N-1:0] ticks;
  logic         valid;
  logic         overflow;
  logic         locked;

  modport master (
    output ena, pulse_in,
    input  ticks, valid, overflow, locked
  );

  modport slave (
    input  ena, pulse_in,
    output ticks, valid, overflow, locked
  );
endinterface

// File: rtl/pulse_period_meter_sync.sv
// Two-flop synchronizer for asynchronous strobe sources; only built with PULSE_METER_SYNC_EN.
`ifdef PULSE_METER_SYNC_EN
module synchronizer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule
`endif

// File: rtl/pulse_period_meter.sv
// Measures spacing of 1-cycle strobes, reported as (cycles between pulses) - 1.
// Define PULSE_METER_SYNC_EN to pass pulse_in through a 2-flop synchronizer first.
module pulse_period_meter
  import pulse_meter_pkg::*;
#(
  parameter int N          = 8,
  parameter int LOCK_COUNT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  pulse_period_meter_if.slave  bus
);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [N-1:0]  CNT_MAX   = {N{1'b1}};
  localparam logic [MW-1:0] MATCH_MAX = MW'(LOCK_COUNT);

  logic pulse;

`ifdef PULSE_METER_SYNC_EN
  logic [0:0] pulse_sync;
  synchronizer #(.WIDTH(1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.pulse_in),
    .q   (pulse_sync)
  );
  assign pulse = pulse_sync[0];
`else
  assign pulse = bus.pulse_in;
`endif

  meter_state_t  state, state_n;
  logic [N-1:0]  counter, counter_n;
  logic [N-1:0]  ticks, ticks_n;
  logic          valid, valid_n;
  logic          overflow, overflow_n;
  logic          locked, locked_n;
  logic [MW-1:0] match, match_n;

  // match is the length of the current run of identical measurements; a differing
  // measurement starts a new run of one rather than zero.
  always_comb begin
    state_n    = state;
    counter_n  = counter;
    ticks_n    = ticks;
    valid_n    = 1'b0;
    overflow_n = overflow;
    locked_n   = locked;
    match_n    = match;
    if (!bus.ena) begin
      state_n   = S_IDLE;
      counter_n = '0;
      locked_n  = 1'b0;
      match_n   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          counter_n = '0;
          if (pulse) state_n = S_MEASURE;
        end
        S_MEASURE: begin
          if (pulse) begin
            ticks_n   = counter;
            valid_n   = 1'b1;
            counter_n = '0;
            if (match != '0 && counter == ticks)
              match_n = (match == MATCH_MAX) ? match : match + 1'b1;
            else
              match_n = MW'(1);
            locked_n = (match_n >= MATCH_MAX);
          end else if (counter == CNT_MAX) begin
            state_n    = S_OVERFLOW;
            overflow_n = 1'b1;
            locked_n   = 1'b0;
            match_n    = '0;
          end else begin
            counter_n = counter + 1'b1;
          end
        end
        S_OVERFLOW: begin
          counter_n = CNT_MAX;
          if (pulse) begin
            state_n    = S_MEASURE;
            counter_n  = '0;
            overflow_n = 1'b0;
          end
        end
        default: begin
          state_n   = S_IDLE;
          counter_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      counter  <= '0;
      ticks    <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
      locked   <= 1'b0;
      match    <= '0;
    end else begin
      state    <= state_n;
      counter  <= counter_n;
      ticks    <= ticks_n;
      valid    <= valid_n;
      overflow <= overflow_n;
      locked   <= locked_n;
      match    <= match_n;
    end
  end

  assign bus.ticks    = ticks;
  assign bus.valid    = valid;
  assign bus.overflow = overflow;
  assign bus.locked   = locked;
endmodule
